// File: rtl/if_id_pipe_ctrl_pkg.sv
// rtl/if_id_pipe_ctrl_pkg.sv - shared front-end types for the IF/ID flow-control stage
package if_id_pipe_ctrl_pkg;

  localparam int FE_XLEN = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [FE_XLEN-1:0] inst;
    logic [FE_XLEN-1:0] pc;
  } fetch_beat_t;

endpackage

// File: rtl/if_id_pipe_ctrl_sat_counter.sv
// rtl/if_id_pipe_ctrl_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment; increment stops at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/if_id_pipe_ctrl.sv
// rtl/if_id_pipe_ctrl.sv - IF-to-ID skid buffer with flush and decode-stall counter
module if_id_pipe_ctrl
  import if_id_pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = FE_XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_inst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [XLEN-1:0]  id_inst,
  output logic [XLEN-1:0]  id_pc,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_e state_q, state_d;
  fetch_beat_t  main_q, main_d;
  fetch_beat_t  skid_q, skid_d;
  fetch_beat_t  beat_in;
  logic         accept;
  logic         consume;
  logic         stall_inc;

  assign beat_in = '{inst: if_inst, pc: if_pc};
  assign accept  = if_valid & if_ready;
  assign consume = id_valid & id_ready;

  // State and buffer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and buffer updates; flush overrides everything, including a same-cycle accept.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = beat_in;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (consume && accept) begin
            main_d = beat_in;
          end else if (consume) begin
            // main keeps its stale value; id_valid masks it
            state_d = ST_EMPTY;
          end else if (accept) begin
            skid_d  = beat_in;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Outputs decode from state and the main register only, so no ready/valid path crosses the stage.
  always_comb begin
    if_ready = (state_q != ST_FULL);
    id_valid = (state_q != ST_EMPTY);
    id_inst  = main_q.inst;
    id_pc    = main_q.pc;
  end

  assign stall_inc = id_valid & ~id_ready & ~flush;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (stall_inc),
    .clr  (stat_clr),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// tb/tb_if_id_pipe_ctrl.sv - directed self-checking bench for if_id_pipe_ctrl
module tb_if_id_pipe_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rstn;
  logic             flush;
  logic             if_valid;
  logic             if_ready;
  logic [XLEN-1:0]  if_inst;
  logic [XLEN-1:0]  if_pc;
  logic             id_valid;
  logic             id_ready;
  logic [XLEN-1:0]  id_inst;
  logic [XLEN-1:0]  id_pc;
  logic             stat_clr;
  logic [CNT_W-1:0] stall_cnt;

  int checks;
  int errors;

  if_id_pipe_ctrl #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_inst   (id_inst),
    .id_pc     (id_pc),
    .stat_clr  (stat_clr),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    checks++;
    if ({if_ready, id_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0", if_ready, id_valid);
    end
    checks++;
    if ({id_inst, id_pc} !== 64'h0 || stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_data got inst=%h pc=%h cnt=%h exp 0 0 0", id_inst, id_pc, stall_cnt);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    logic [XLEN-1:0] pcs [3];
    logic [XLEN-1:0] insts [3];
    pcs   = '{32'h0, 32'h4, 32'h8};
    insts = '{32'h00000013, 32'h00100093, 32'h00200113};
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(pcs[i], insts[i]);
      step();
      checks++;
      if ({if_ready, id_valid} !== 2'b11 || id_pc !== pcs[i] || id_inst !== insts[i]) begin
        errors++;
        $display("FAIL stream_beat%0d got rdy=%b vld=%b pc=%h inst=%h exp rdy=1 vld=1 pc=%h inst=%h",
                 i, if_ready, id_valid, id_pc, id_inst, pcs[i], insts[i]);
      end
    end
    if_valid = 1'b0;
    step();
    checks++;
    if (id_valid !== 1'b0 || stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL stream_drain got vld=%b cnt=%h exp vld=0 cnt=0", id_valid, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    send(32'h100, 32'hA0);
    step();
    send(32'h104, 32'hA4);
    step();
    if_valid = 1'b0;
    checks++;
    if ({if_ready, id_valid} !== 2'b01 || id_pc !== 32'h100) begin
      errors++;
      $display("FAIL bp_full got rdy=%b vld=%b pc=%h exp rdy=0 vld=1 pc=00000100", if_ready, id_valid, id_pc);
    end
    step();
    checks++;
    if (if_ready !== 1'b0 || id_pc !== 32'h100 || stall_cnt !== 4'h2) begin
      errors++;
      $display("FAIL bp_hold got rdy=%b pc=%h cnt=%h exp rdy=0 pc=00000100 cnt=2", if_ready, id_pc, stall_cnt);
    end
    id_ready = 1'b1;
    step();
    checks++;
    if ({if_ready, id_valid} !== 2'b11 || id_pc !== 32'h104 || id_inst !== 32'hA4) begin
      errors++;
      $display("FAIL bp_second got rdy=%b vld=%b pc=%h inst=%h exp rdy=1 vld=1 pc=00000104 inst=000000a4",
               if_ready, id_valid, id_pc, id_inst);
    end
    step();
    checks++;
    if (id_valid !== 1'b0 || if_ready !== 1'b1 || stall_cnt !== 4'h2) begin
      errors++;
      $display("FAIL bp_drain got vld=%b rdy=%b cnt=%h exp vld=0 rdy=1 cnt=2", id_valid, if_ready, stall_cnt);
    end
  endtask

  task automatic test_flush_full();
    id_ready = 1'b0;
    send(32'h300, 32'hB0);
    step();
    send(32'h304, 32'hB4);
    step();
    send(32'h200, 32'hC0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    if_valid = 1'b0;
    checks++;
    if ({if_ready, id_valid} !== 2'b10 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
      errors++;
      $display("FAIL flush_state got rdy=%b vld=%b pc=%h inst=%h exp rdy=1 vld=0 pc=0 inst=0",
               if_ready, id_valid, id_pc, id_inst);
    end
    checks++;
    if (stall_cnt !== 4'h3) begin
      errors++;
      $display("FAIL flush_cnt got %h exp 3", stall_cnt);
    end
    id_ready = 1'b1;
    step();
    step();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_nodeliver got vld=%b pc=%h exp vld=0", id_valid, id_pc);
    end
  endtask

  task automatic test_consume_accept();
    id_ready = 1'b0;
    send(32'h10, 32'hD0);
    step();
    id_ready = 1'b1;
    send(32'h14, 32'hD4);
    step();
    if_valid = 1'b0;
    checks++;
    if ({if_ready, id_valid} !== 2'b11 || id_pc !== 32'h14 || id_inst !== 32'hD4) begin
      errors++;
      $display("FAIL ca_replace got rdy=%b vld=%b pc=%h inst=%h exp rdy=1 vld=1 pc=00000014 inst=000000d4",
               if_ready, id_valid, id_pc, id_inst);
    end
    step();
    checks++;
    if (id_valid !== 1'b0 || stall_cnt !== 4'h3) begin
      errors++;
      $display("FAIL ca_empty got vld=%b cnt=%h exp vld=0 cnt=3", id_valid, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    id_ready = 1'b0;
    send(32'h20, 32'hE0);
    step();
    if_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_reach got %h exp f", stall_cnt);
    end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold got %h exp f", stall_cnt);
    end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    checks++;
    if (stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL sat_clr got %h exp 0", stall_cnt);
    end
    step();
    checks++;
    if (stall_cnt !== 4'h1) begin
      errors++;
      $display("FAIL sat_restart got %h exp 1", stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    send(32'h400, 32'hF0);
    step();
    if_valid = 1'b0;
    checks++;
    if (if_ready !== 1'b0 || id_pc !== 32'h20) begin
      errors++;
      $display("FAIL ar_full got rdy=%b pc=%h exp rdy=0 pc=00000020", if_ready, id_pc);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({if_ready, id_valid} !== 2'b10 || id_pc !== 32'h0 || id_inst !== 32'h0 || stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL ar_immediate got rdy=%b vld=%b pc=%h inst=%h cnt=%h exp rdy=1 vld=0 pc=0 inst=0 cnt=0",
               if_ready, id_valid, id_pc, id_inst, stall_cnt);
    end
    #1;
    rstn     = 1'b1;
    id_ready = 1'b1;
    send(32'h500, 32'h55);
    step();
    if_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h500 || id_inst !== 32'h55) begin
      errors++;
      $display("FAIL ar_after got vld=%b pc=%h inst=%h exp vld=1 pc=00000500 inst=00000055", id_valid, id_pc, id_inst);
    end
    step();
    checks++;
    if (id_valid !== 1'b0 || stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL ar_drain got vld=%b cnt=%h exp vld=0 cnt=0", id_valid, stall_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_inst  = '0;
    if_pc    = '0;
    id_ready = 1'b0;
    stat_clr = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_consume_accept();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_ctrl.md
Name: if_id_pipe_ctrl

Overview:
- Flow-control stage between the IF and ID stages of the out-of-order core front end.
- Replaces the unconditional IF-to-ID instruction register with a 2-entry (main + skid) buffer that carries instruction and PC.
- Supports a valid/ready handshake on both sides, back-pressure from decode/rename, and a flush on branch mispredict or exception redirect.
- Keeps a saturating count of decode-stall cycles for performance monitoring.

Parameters:
- XLEN, 32, width of the instruction and PC fields.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush (mispredict or redirect).
- if_valid  input  1  IF presents a valid instruction.
- if_ready  output  1  stage can accept a beat this cycle.
- if_inst  input  XLEN  fetched instruction.
- if_pc  input  XLEN  PC of the fetched instruction.
- id_valid  output  1  ID-side beat valid.
- id_ready  input  1  ID consumes the beat this cycle.
- id_inst  output  XLEN  instruction to decode.
- id_pc  output  XLEN  PC to decode.
- stat_clr  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  CNT_W  saturating count of cycles with id_valid=1 and id_ready=0.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=EMPTY.
  - main and skid registers = 0.
  - if_ready=1, id_valid=0, id_inst=0, id_pc=0, stall_cnt=0.
- Handshake definitions:
  - accept = if_valid & if_ready.
  - consume = id_valid & id_ready.
- Outputs are registered or decoded from state only. There is no combinational path from id_ready to if_ready, or from if_* to id_*.
  - if_ready = (state != FULL).
  - id_valid = (state != EMPTY).
  - id_inst and id_pc always drive the main register.
- Latency: an accepted beat appears on id_* on the next cycle when the stage was EMPTY, or when the stage was BUSY and consumed that cycle.
- EMPTY:
  - accept: main <= in, go to BUSY.
  - otherwise: stay.
- BUSY:
  - consume & accept: main <= in, stay BUSY.
  - consume & !accept: go to EMPTY; main holds its stale value.
  - !consume & accept: skid <= in, go to FULL.
  - !consume & !accept: hold.
- FULL:
  - if_ready=0, so no accept is possible.
  - consume: main <= skid, go to BUSY.
  - otherwise: hold.
- Ordering: beats leave strictly in acceptance order. No beat is dropped except by flush, and no beat is duplicated.
- Flush:
  - Highest priority, sampled on the clock edge.
  - Next state is EMPTY; main and skid are cleared to 0.
  - Any same-cycle accept is discarded and does not count as a transfer.
  - A same-cycle consume still counts as a transfer on the ID side.
  - if_ready=1 and id_valid=0 on the following cycle.
- Stall counter:
  - Increments by 1 each cycle in which id_valid & !id_ready and flush=0.
  - Saturates at all-ones; no wrap.
  - stat_clr loads 0 and has priority over increment.
  - Unaffected by flush.
- Reset asserted mid-operation: immediate return to the reset values; in-flight beats are lost.
- Illegal state encoding: recover to EMPTY.

Decomposition:
- Shared front-end package holds:
  - XLEN constant;
  - stage-state enum (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2);
  - fetch-beat struct {inst, pc}.
- The 2-entry buffer and FSM stay in one module.
- The stall counter is a natural sub-module, sat_counter (parameter W; ports clk, rstn, inc, clr, cnt), reusable for other stage performance counters.

Test Plan:
- Streaming: id_ready=1; IF sends pc 0x0,0x4,0x8 with inst 0x00000013,0x00100093,0x00200113 on consecutive cycles -> id_* shows each beat one cycle later; if_ready stays 1; stall_cnt=0.
- Back-pressure fill: id_ready=0; send pc 0x100 then 0x104 -> FULL after the second beat, if_ready=0, id_pc=0x100. Raise id_ready for 2 cycles -> 0x100 then 0x104 delivered in order; if_ready returns to 1; stall_cnt=2.
- Flush while FULL, with if_valid=1 presenting pc 0x200 the same cycle -> next cycle id_valid=0, id_pc=0, if_ready=1; pc 0x200 is never delivered.
- Simultaneous consume & accept in BUSY, main pc 0x10 and incoming pc 0x14 -> next cycle id_pc=0x14, state BUSY, skid unused.
- Counter saturation with CNT_W=4: hold id_valid=1, id_ready=0 for 20 cycles -> stall_cnt stops at 0xF. Then assert stat_clr together with a stall cycle -> 0.
- Async reset asserted mid-cycle while FULL -> outputs go to reset values immediately without waiting for a clock edge; after release the first accepted beat goes through normally.
